// File: rtl/dbus_resp_model.sv
// Single-port dbus responder: one request in flight, fixed-latency data_ok, byte-strobed writes.
// Optional DBUS_RANDOM_DELAY_EN adds 0..3 LFSR-chosen extra cycles of latency per transaction.
module dbus_resp_model #(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [3:0]  req_strobe,
    input  logic [31:0] req_data,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] resp_data,
    output logic        misalign
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned CNT_W = $clog2(LATENCY + 4) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_load;
    logic [31:0]      addr_q, addr_d;
    logic [2:0]       size_q, size_d;
    logic [3:0]       strobe_q, strobe_d;
    logic [31:0]      data_q, data_d;
    logic             misalign_q, misalign_d;

    logic [31:0]      mem [MEM_WORDS];
    logic [IDX_W-1:0] word_idx;
    logic             legal;
    logic             accept;
    logic             done;
    logic             do_write;

`ifdef DBUS_RANDOM_DELAY_EN
    logic [7:0] lfsr_q, lfsr_d;

    assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign cnt_load = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_q[1:0]);

    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= 8'hA5;
        else       lfsr_q <= lfsr_d;
    end
`else
    assign cnt_load = CNT_W'(LATENCY - 1);
`endif

    assign word_idx = IDX_W'((addr_q - BASE_ADDR) >> 2);

    always_comb begin
        legal = 1'b0;
        case (size_q)
            3'd0:    legal = 1'b1;
            3'd1:    legal = ~addr_q[0];
            3'd2:    legal = (addr_q[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    assign accept   = (state_q == IDLE) && req_valid && !reset;
    assign done     = (state_q == DONE) && !reset;
    assign do_write = done && legal && (strobe_q != 4'h0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        size_d     = size_q;
        strobe_d   = strobe_q;
        data_d     = data_q;
        misalign_d = misalign_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d   = req_addr;
                    size_d   = req_size;
                    strobe_d = req_strobe;
                    data_d   = req_data;
                    cnt_d    = cnt_load;
                    state_d  = (cnt_load == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                if (!legal) misalign_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            size_q     <= '0;
            strobe_q   <= '0;
            data_q     <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            strobe_q   <= strobe_d;
            data_q     <= data_d;
            misalign_q <= misalign_d;
        end
    end

    // Array is never cleared by reset; only the strobed lanes of a legal write change.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (strobe_q[k]) mem[word_idx][8*k +: 8] <= data_q[8*k +: 8];
            end
        end
    end

    assign addr_ok   = accept;
    assign data_ok   = done;
    assign resp_data = (done && legal && (strobe_q == 4'h0)) ? mem[word_idx] : '0;
    assign misalign  = misalign_q && !reset;

endmodule
